mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single memory port of the rv32-4way-1port Sodor core between the instruction-fetch requester and the data-memory requester. It sits between the core's imem/dmem request interfaces and the one physical memory port. It arbitrates requests with data priority plus a fetch-starvation guard. It tracks outstanding requests in order so each memory response is routed back to the requester that issued it.

## Interface
- ADDR_W, 32, request address width
- DATA_W, 32, data width; must be a multiple of 8
- MAX_OUT, 2, maximum outstanding (accepted, unanswered) requests; 1..4
- STARVE_LIMIT, 4, consecutive cycles a pending fetch may be denied before it is forced through; 1..15

- clock  in  1  sole clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset
- io_imem_req_valid  in  1  fetch request pending
- io_imem_req_addr  in  ADDR_W  fetch address
- io_imem_req_ready  out  1  fetch request accepted this cycle
- io_imem_resp_valid  out  1  fetch response valid (single-cycle pulse)
- io_imem_resp_data  out  DATA_W  fetched word
- io_dmem_req_valid  in  1  data request pending
- io_dmem_req_addr  in  ADDR_W  data address
- io_dmem_req_wdata  in  DATA_W  store data
- io_dmem_req_wmask  in  DATA_W/8  byte enables for stores
- io_dmem_req_fcn  in  1  1 = write, 0 = read
- io_dmem_req_ready  out  1  data request accepted this cycle
- io_dmem_resp_valid  out  1  data response valid (single-cycle pulse)
- io_dmem_resp_data  out  DATA_W  load data; don't-care for stores
- io_mem_req_valid  out  1  request to memory
- io_mem_req_addr / io_mem_req_wdata / io_mem_req_wmask / io_mem_req_fcn  out  ADDR_W / DATA_W / DATA_W/8 / 1  muxed request fields
- io_mem_req_ready  in  1  memory accepts request
- io_mem_resp_valid  in  1  memory response; returned in request order, one per request, including writes
- io_mem_resp_data  in  DATA_W  response data
- io_err  out  1  sticky flag: a response arrived with nothing outstanding

## Operation
- Owner FIFO:
  - depth MAX_OUT, 1-bit entries (0 = imem, 1 = dmem), plus a count register of width clog2(MAX_OUT+1).
  - Each accepted request pushes its owner.
  - Each io_mem_resp_valid pops the head.
- Grant condition: grant is possible only when io_mem_req_ready=1 and the FIFO is not full. A full FIFO blocks new grants even if a pop occurs in the same cycle.
- Priority:
  - dmem wins when both requesters are valid.
  - Exception: if starve_cnt == STARVE_LIMIT, imem wins.
- Starvation counter:
  - starve_cnt increments (saturating at STARVE_LIMIT) each cycle io_imem_req_valid=1 and imem is not granted.
  - It clears on an imem grant or when io_imem_req_valid=0.
- Request path:
  - io_mem_req_valid = (imem or dmem valid) && FIFO not full.
  - The request fields are muxed from the selected requester.
  - For imem: fcn=0, wmask=0, wdata=0.
- Ready outputs: io_imem_req_ready / io_dmem_req_ready = 1 only for the granted requester, in the cycle of acceptance. Both are combinational.
- Response path:
  - On io_mem_resp_valid, data is forwarded combinationally to the owner at the FIFO head, with that owner's resp_valid=1.
  - The other owner's resp_valid stays 0.
- Spurious response: a response with count==0 is dropped, sets io_err, and leaves the FIFO unchanged. io_err clears only on reset.
- Simultaneous push and pop: the count is unchanged and the order is preserved.

## Timing
- Reset (reset=0, asynchronous):
  - FIFO emptied, count=0, starve_cnt=0, io_err=0.
  - All ready and valid outputs are forced to 0 while reset=0.
- Arbitration adds zero latency: a request accepted in cycle N appears on the memory port in cycle N.
- Response latency equals memory latency plus 0 cycles.
- Throughput: one grant per cycle. A fetch denied STARVE_LIMIT consecutive cycles is granted on the next cycle memory can accept.
- Reset mid-operation: all outstanding entries are discarded. Responses arriving after reset release are treated as spurious and set io_err.
- FIFO pointers wrap modulo MAX_OUT. Count never exceeds MAX_OUT.

## Test plan
- Lone fetch: imem valid, addr 0x100, memory returns 0x00000013 one cycle later -> imem_req_ready=1 in the accept cycle, mem_req_addr=0x100, imem_resp_valid pulse with data 0x00000013, dmem_resp_valid=0.
- Contention: imem and dmem valid every cycle, STARVE_LIMIT=4, memory always ready, MAX_OUT=4, responses after 1 cycle -> grants follow d,d,d,d,i,d,d,d,d,i, with no imem gap longer than 4 cycles.
- In-order routing: issue i(0x0), d-store(0x40, wdata 0xDEADBEEF, mask 0xF), i(0x4), with responses A, B, C -> A to imem, B to dmem, C to imem.
- Full FIFO: MAX_OUT=2, memory withholds responses -> after 2 grants mem_req_valid=0 and both readies=0; one response frees exactly one grant, the next cycle.
- Spurious response: mem_resp_valid with nothing outstanding -> no resp_valid pulses, io_err=1 and held until reset.
- Reset with 2 outstanding: pulse reset low mid-transaction -> outputs 0 immediately, count=0; a subsequent stale response sets io_err.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch (imem) and data (dmem) requesters.
// Data requests win unless a pending fetch has been denied STARVE_LIMIT
// consecutive cycles. A small owner FIFO remembers who issued each accepted
// request so in-order memory responses are routed back to the right side.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_OUT      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_imem_req_valid,
    input  logic [ADDR_W-1:0]     io_imem_req_addr,
    output logic                  io_imem_req_ready,
    output logic                  io_imem_resp_valid,
    output logic [DATA_W-1:0]     io_imem_resp_data,
    input  logic                  io_dmem_req_valid,
    input  logic [ADDR_W-1:0]     io_dmem_req_addr,
    input  logic [DATA_W-1:0]     io_dmem_req_wdata,
    input  logic [DATA_W/8-1:0]   io_dmem_req_wmask,
    input  logic                  io_dmem_req_fcn,
    output logic                  io_dmem_req_ready,
    output logic                  io_dmem_resp_valid,
    output logic [DATA_W-1:0]     io_dmem_resp_data,
    output logic                  io_mem_req_valid,
    output logic [ADDR_W-1:0]     io_mem_req_addr,
    output logic [DATA_W-1:0]     io_mem_req_wdata,
    output logic [DATA_W/8-1:0]   io_mem_req_wmask,
    output logic                  io_mem_req_fcn,
    input  logic                  io_mem_req_ready,
    input  logic                  io_mem_resp_valid,
    input  logic [DATA_W-1:0]     io_mem_resp_data,
    output logic                  io_err
);

    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int STV_W = 4;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUT);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

    // Owner entries: 0 = imem, 1 = dmem.
    logic [MAX_OUT-1:0] owner_q, owner_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STV_W-1:0]   starve_q, starve_d;
    logic               err_q, err_d;

    logic run;
    logic full;
    logic empty;
    logic any_req;
    logic imem_sel;
    logic grant;
    logic grant_i;
    logic grant_d;
    logic pop;
    logic head_owner;

    // Pointers wrap modulo MAX_OUT, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Outputs are silenced while reset is held, independent of the clock.
    assign run = reset;

    // Arbitration: who is selected, and whether anything is accepted this cycle.
    always_comb begin
        full       = (cnt_q == CNT_FULL);
        empty      = (cnt_q == '0);
        any_req    = io_imem_req_valid || io_dmem_req_valid;
        imem_sel   = io_imem_req_valid && (!io_dmem_req_valid || (starve_q == STV_MAX));
        // A full FIFO blocks grants even when a response pops in the same cycle.
        grant      = run && io_mem_req_ready && !full && any_req;
        grant_i    = grant && imem_sel;
        grant_d    = grant && !imem_sel;
        pop        = run && io_mem_resp_valid && !empty;
        head_owner = owner_q[rd_ptr_q];
    end

    assign io_mem_req_valid   = run && any_req && !full;
    assign io_mem_req_addr    = imem_sel ? io_imem_req_addr : io_dmem_req_addr;
    assign io_mem_req_wdata   = imem_sel ? '0 : io_dmem_req_wdata;
    assign io_mem_req_wmask   = imem_sel ? '0 : io_dmem_req_wmask;
    assign io_mem_req_fcn     = !imem_sel && io_dmem_req_fcn;

    assign io_imem_req_ready  = grant_i;
    assign io_dmem_req_ready  = grant_d;

    assign io_imem_resp_valid = pop && !head_owner;
    assign io_dmem_resp_valid = pop && head_owner;
    assign io_imem_resp_data  = io_mem_resp_data;
    assign io_dmem_resp_data  = io_mem_resp_data;

    assign io_err             = err_q;

    // Next state: owner FIFO push/pop, sticky error, starvation counter.
    always_comb begin
        owner_d  = owner_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (grant) begin
            owner_d[wr_ptr_q] = grant_d;
            wr_ptr_d          = ptr_next(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        case ({grant, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        // A response with nothing outstanding is dropped and flagged.
        err_d = err_q || (io_mem_resp_valid && empty);

        if (!io_imem_req_valid || grant_i) begin
            starve_d = '0;
        end else if (starve_q != STV_MAX) begin
            starve_d = starve_q + 1'b1;
        end else begin
            starve_d = starve_q;
        end
    end

    // State registers; reset discards every outstanding entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            owner_q  <= owner_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic against a queue-based model of
// the arbiter; a negedge process compares every output each cycle.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;
    localparam int MAX_OUT = 2;
    localparam int SL = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          io_imem_req_valid;
    logic [AW-1:0] io_imem_req_addr;
    logic          io_imem_req_ready;
    logic          io_imem_resp_valid;
    logic [DW-1:0] io_imem_resp_data;
    logic          io_dmem_req_valid;
    logic [AW-1:0] io_dmem_req_addr;
    logic [DW-1:0] io_dmem_req_wdata;
    logic [MW-1:0] io_dmem_req_wmask;
    logic          io_dmem_req_fcn;
    logic          io_dmem_req_ready;
    logic          io_dmem_resp_valid;
    logic [DW-1:0] io_dmem_resp_data;
    logic          io_mem_req_valid;
    logic [AW-1:0] io_mem_req_addr;
    logic [DW-1:0] io_mem_req_wdata;
    logic [MW-1:0] io_mem_req_wmask;
    logic          io_mem_req_fcn;
    logic          io_mem_req_ready;
    logic          io_mem_resp_valid;
    logic [DW-1:0] io_mem_resp_data;
    logic          io_err;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MAX_OUT), .STARVE_LIMIT(SL)
    ) dut (
        .clock(clock), .reset(reset),
        .io_imem_req_valid(io_imem_req_valid), .io_imem_req_addr(io_imem_req_addr),
        .io_imem_req_ready(io_imem_req_ready), .io_imem_resp_valid(io_imem_resp_valid),
        .io_imem_resp_data(io_imem_resp_data),
        .io_dmem_req_valid(io_dmem_req_valid), .io_dmem_req_addr(io_dmem_req_addr),
        .io_dmem_req_wdata(io_dmem_req_wdata), .io_dmem_req_wmask(io_dmem_req_wmask),
        .io_dmem_req_fcn(io_dmem_req_fcn), .io_dmem_req_ready(io_dmem_req_ready),
        .io_dmem_resp_valid(io_dmem_resp_valid), .io_dmem_resp_data(io_dmem_resp_data),
        .io_mem_req_valid(io_mem_req_valid), .io_mem_req_addr(io_mem_req_addr),
        .io_mem_req_wdata(io_mem_req_wdata), .io_mem_req_wmask(io_mem_req_wmask),
        .io_mem_req_fcn(io_mem_req_fcn), .io_mem_req_ready(io_mem_req_ready),
        .io_mem_resp_valid(io_mem_resp_valid), .io_mem_resp_data(io_mem_resp_data),
        .io_err(io_err)
    );

    always #5 clock = ~clock;

    // Model: list of owners in issue order, fetch-denial count, sticky error.
    bit m_own[$];
    int m_starve = 0;
    bit m_err = 1'b0;

    bit e_isel, e_mvalid, e_gi, e_gd, e_pop, e_ir, e_dr;

    function automatic void eval_model();
        bit full_now;
        full_now = (m_own.size() == MAX_OUT);
        e_isel   = io_imem_req_valid && (!io_dmem_req_valid || m_starve == SL);
        e_mvalid = (io_imem_req_valid || io_dmem_req_valid) && !full_now;
        e_gi     = e_mvalid && io_mem_req_ready && e_isel;
        e_gd     = e_mvalid && io_mem_req_ready && !e_isel;
        e_pop    = io_mem_resp_valid && (m_own.size() > 0);
        e_ir     = e_pop ? (m_own[0] == 1'b0) : 1'b0;
        e_dr     = e_pop ? (m_own[0] == 1'b1) : 1'b0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance the model at each clock edge; reset empties it.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_own.delete();
            m_starve = 0;
            m_err = 1'b0;
        end else begin
            eval_model();
            if (io_mem_resp_valid) begin
                if (m_own.size() > 0) void'(m_own.pop_front());
                else m_err = 1'b1;
            end
            if (e_gi) m_own.push_back(1'b0);
            else if (e_gd) m_own.push_back(1'b1);
            if (!io_imem_req_valid || e_gi) m_starve = 0;
            else if (m_starve < SL) m_starve++;
        end
    end

    // Compare every DUT output against the model mid-cycle.
    always @(negedge clock) begin
        if (!reset) begin
            chk("rst_mem_req_valid", io_mem_req_valid, 0);
            chk("rst_imem_ready", io_imem_req_ready, 0);
            chk("rst_dmem_ready", io_dmem_req_ready, 0);
            chk("rst_imem_resp_valid", io_imem_resp_valid, 0);
            chk("rst_dmem_resp_valid", io_dmem_resp_valid, 0);
            chk("rst_err", io_err, 0);
        end else begin
            eval_model();
            chk("mem_req_valid", io_mem_req_valid, e_mvalid);
            chk("imem_req_ready", io_imem_req_ready, e_gi);
            chk("dmem_req_ready", io_dmem_req_ready, e_gd);
            if (e_mvalid) begin
                chk("mem_req_addr", io_mem_req_addr, e_isel ? io_imem_req_addr : io_dmem_req_addr);
                chk("mem_req_wdata", io_mem_req_wdata, e_isel ? '0 : io_dmem_req_wdata);
                chk("mem_req_wmask", io_mem_req_wmask, e_isel ? '0 : io_dmem_req_wmask);
                chk("mem_req_fcn", io_mem_req_fcn, e_isel ? 1'b0 : io_dmem_req_fcn);
            end
            chk("imem_resp_valid", io_imem_resp_valid, e_ir);
            chk("dmem_resp_valid", io_dmem_resp_valid, e_dr);
            if (e_ir) chk("imem_resp_data", io_imem_resp_data, io_mem_resp_data);
            if (e_dr) chk("dmem_resp_data", io_dmem_resp_data, io_mem_resp_data);
            chk("err", io_err, m_err);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        io_imem_req_valid = 0; io_imem_req_addr = '0;
        io_dmem_req_valid = 0; io_dmem_req_addr = '0;
        io_dmem_req_wdata = '0; io_dmem_req_wmask = '0; io_dmem_req_fcn = 0;
        io_mem_req_ready = 0; io_mem_resp_valid = 0; io_mem_resp_data = '0;
    endtask

    string pat;
    byte   g;

    initial begin
        reset = 1'b0;
        idle_inputs();
        // Requests present while reset is held must not be accepted.
        io_imem_req_valid = 1; io_dmem_req_valid = 1; io_mem_req_ready = 1;
        #1;
        chk("lit_rst_mvalid", io_mem_req_valid, 0);
        chk("lit_rst_ready", {io_imem_req_ready, io_dmem_req_ready}, 0);
        repeat (2) @(posedge clock);
        #1;
        idle_inputs();
        reset = 1'b1;
        #5;
        chk("lit_after_rst_err", io_err, 0);
        chk("lit_after_rst_mvalid", io_mem_req_valid, 0);

        // Lone fetch
        tick();
        io_imem_req_valid = 1; io_imem_req_addr = 32'h100; io_mem_req_ready = 1;
        #5;
        chk("lit_fetch_ready", io_imem_req_ready, 1);
        chk("lit_fetch_addr", io_mem_req_addr, 32'h100);
        chk("lit_fetch_dready", io_dmem_req_ready, 0);
        tick();
        io_imem_req_valid = 0; io_mem_resp_valid = 1; io_mem_resp_data = 32'h0000_0013;
        #5;
        chk("lit_fetch_resp_valid", io_imem_resp_valid, 1);
        chk("lit_fetch_resp_data", io_imem_resp_data, 32'h0000_0013);
        chk("lit_fetch_dresp", io_dmem_resp_valid, 0);
        tick();
        io_mem_resp_valid = 0;

        // Contention with 1-cycle responses
        pat = "ddddiddddi";
        io_imem_req_valid = 1; io_dmem_req_valid = 1; io_mem_req_ready = 1;
        for (int k = 0; k < 10; k++) begin
            io_mem_resp_valid = (k > 0);
            io_mem_resp_data = 32'h1000 + k;
            #5;
            g = io_imem_req_ready ? "i" : (io_dmem_req_ready ? "d" : "-");
            chk($sformatf("lit_contention_%0d", k), g, pat[k]);
            tick();
        end
        io_imem_req_valid = 0; io_dmem_req_valid = 0; io_mem_resp_valid = 1;
        tick();
        io_mem_resp_valid = 0;

        // In-order routing: i(0x0), d-store(0x40), i(0x4)
        io_imem_req_valid = 1; io_imem_req_addr = 32'h0;
        #5;
        chk("lit_order_i0_ready", io_imem_req_ready, 1);
        tick();
        io_imem_req_valid = 0;
        io_dmem_req_valid = 1; io_dmem_req_addr = 32'h40; io_dmem_req_wdata = 32'hDEADBEEF;
        io_dmem_req_wmask = 4'hF; io_dmem_req_fcn = 1;
        #5;
        chk("lit_order_d_ready", io_dmem_req_ready, 1);
        chk("lit_order_d_wdata", io_mem_req_wdata, 32'hDEADBEEF);
        chk("lit_order_d_wmask", io_mem_req_wmask, 4'hF);
        chk("lit_order_d_fcn", io_mem_req_fcn, 1);
        tick();
        io_dmem_req_valid = 0; io_dmem_req_fcn = 0;
        io_imem_req_valid = 1; io_imem_req_addr = 32'h4;
        io_mem_resp_valid = 1; io_mem_resp_data = 32'hAAAA_0001;
        #5;
        chk("lit_order_A_imem", io_imem_resp_valid, 1);
        chk("lit_order_A_data", io_imem_resp_data, 32'hAAAA_0001);
        chk("lit_order_full_blocks", io_imem_req_ready, 0);
        tick();
        io_mem_resp_data = 32'hBBBB_0002;
        #5;
        chk("lit_order_B_dmem", io_dmem_resp_valid, 1);
        chk("lit_order_B_not_imem", io_imem_resp_valid, 0);
        chk("lit_order_i4_ready", io_imem_req_ready, 1);
        chk("lit_order_i4_addr", io_mem_req_addr, 32'h4);
        tick();
        io_imem_req_valid = 0; io_mem_resp_data = 32'hCCCC_0003;
        #5;
        chk("lit_order_C_imem", io_imem_resp_valid, 1);
        chk("lit_order_C_data", io_imem_resp_data, 32'hCCCC_0003);
        tick();
        io_mem_resp_valid = 0;

        // Full FIFO with withheld responses; starvation guard then frees fetch
        io_imem_req_valid = 1; io_imem_req_addr = 32'h200;
        io_dmem_req_valid = 1; io_dmem_req_addr = 32'h300;
        tick();
        tick();
        #5;
        chk("lit_full_mvalid", io_mem_req_valid, 0);
        chk("lit_full_readies", {io_imem_req_ready, io_dmem_req_ready}, 0);
        tick();
        io_mem_resp_valid = 1;
        #5;
        chk("lit_full_pop_still_blocked", {io_imem_req_ready, io_dmem_req_ready}, 0);
        tick();
        io_mem_resp_valid = 0;
        #5;
        chk("lit_full_one_grant_starved_fetch", io_imem_req_ready, 1);
        chk("lit_full_fetch_addr", io_mem_req_addr, 32'h200);
        tick();
        #5;
        chk("lit_full_again", io_mem_req_valid, 0);
        tick();
        io_imem_req_valid = 0; io_dmem_req_valid = 0; io_mem_resp_valid = 1;
        tick();
        tick();

        // Spurious response
        #5;
        chk("lit_spur_no_imem", io_imem_resp_valid, 0);
        chk("lit_spur_no_dmem", io_dmem_resp_valid, 0);
        tick();
        io_mem_resp_valid = 0;
        #5;
        chk("lit_spur_err", io_err, 1);
        repeat (3) tick();
        chk("lit_spur_err_held", io_err, 1);
        reset = 0;
        #1;
        chk("lit_spur_err_cleared", io_err, 0);
        tick();
        reset = 1;

        // Reset with two outstanding
        io_dmem_req_valid = 1; io_dmem_req_addr = 32'h500;
        tick();
        tick();
        io_mem_resp_valid = 1; io_mem_resp_data = 32'h55;
        reset = 0;
        #1;
        chk("lit_midrst_mvalid", io_mem_req_valid, 0);
        chk("lit_midrst_dready", io_dmem_req_ready, 0);
        chk("lit_midrst_resp", {io_imem_resp_valid, io_dmem_resp_valid}, 0);
        tick();
        reset = 1; io_dmem_req_valid = 0;
        #5;
        chk("lit_stale_resp", {io_imem_resp_valid, io_dmem_resp_valid}, 0);
        tick();
        io_mem_resp_valid = 0;
        #5;
        chk("lit_stale_err", io_err, 1);
        tick();
        reset = 0;
        tick();
        reset = 1;

        // Randomized traffic; memory answers only what is outstanding
        for (int n = 0; n < 3000; n++) begin
            io_imem_req_valid = ($urandom_range(0, 3) != 0);
            io_imem_req_addr  = $urandom;
            io_dmem_req_valid = ($urandom_range(0, 2) != 0);
            io_dmem_req_addr  = $urandom;
            io_dmem_req_wdata = $urandom;
            io_dmem_req_wmask = MW'($urandom);
            io_dmem_req_fcn   = $urandom_range(0, 1);
            io_mem_req_ready  = ($urandom_range(0, 3) != 0);
            io_mem_resp_valid = (m_own.size() > 0) && ($urandom_range(0, 2) != 0);
            io_mem_resp_data  = $urandom;
            tick();
        end
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
